// File: rtl/mboot_pkg.sv
// Shared types and constants for the multiboot request front-end.
// State encoding, default image address map and the image-count ceiling.
package mboot_pkg;

    typedef enum logic [2:0] {
        LOCKOUT,
        IDLE,
        PRESS,
        FIRE,
        WAIT_REL
    } state_t;

    localparam logic [7:0] DEF_IMG_BASE   = 8'h00;
    localparam logic [7:0] DEF_IMG_STRIDE = 8'h0a;
    localparam int         MAX_IMG        = 4;

    // Image address wraps modulo 256 by construction of the 8-bit result.
    function automatic logic [7:0] img_addr(input logic [7:0] base,
                                            input logic [7:0] stride,
                                            input logic [1:0] sel);
        logic [7:0] off;
        off = stride * {6'd0, sel};
        return base + off;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for an active-low key.
// Debounced level follows a clean edge after 2 + DEBOUNCE_CYC cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic settled
);

    localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level;
    logic          raw_pressed;

    assign raw_pressed = ~sync2;
    assign settled     = (raw_pressed == level);
    assign pressed     = level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (settled) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= raw_pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mboot_req_ctrl.sv
// Key front-end for the multiboot primitive: short press steps the image, long press fires REBOOT_N.
// REBOOT_N falls LONG_CYC cycles after KEY_PRESSED rises and stays low for PULSE_CYC cycles.
module mboot_req_ctrl
    import mboot_pkg::*;
#(
    parameter int         DEBOUNCE_CYC = 240000,
    parameter int         LONG_CYC     = 48000000,
    parameter int         PULSE_CYC    = 24,
    parameter int         NUM_IMG      = 3,
    parameter logic [7:0] IMG_BASE     = DEF_IMG_BASE,
    parameter logic [7:0] IMG_STRIDE   = DEF_IMG_STRIDE
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       KEY_N,
    output logic       REBOOT_N,
    output logic [7:0] IMAGE_ADDR,
    output logic [1:0] IMG_SEL,
    output logic       KEY_PRESSED,
    output logic       BUSY
);

    localparam int N_IMG = (NUM_IMG < 1) ? 1 : ((NUM_IMG > MAX_IMG) ? MAX_IMG : NUM_IMG);
    localparam int HW    = $clog2(LONG_CYC);
    localparam int PW    = $clog2(PULSE_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX   = '1;
    localparam logic [HW-1:0] LOCK_LAST  = HW'(2);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
    localparam logic [1:0]    SEL_LAST   = 2'(N_IMG - 1);

    state_t        state;
    logic [HW-1:0] hold;
    logic [PW-1:0] pulse;
    logic [1:0]    img_sel;
    logic [7:0]    image_addr;
    logic          reboot_n;
    logic          busy;
    logic          pressed;
    logic          settled;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk    (CLK_IN),
        .rst    (RST),
        .key_n  (KEY_N),
        .pressed(pressed),
        .settled(settled)
    );

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state      <= LOCKOUT;
            hold       <= '0;
            pulse      <= '0;
            img_sel    <= 2'd0;
            image_addr <= IMG_BASE;
            reboot_n   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            if (state != FIRE && state != WAIT_REL)
                image_addr <= img_addr(IMG_BASE, IMG_STRIDE, img_sel);

            case (state)
                // Leave only once the synchronizer has flushed and the key reads released.
                LOCKOUT: begin
                    if (!pressed && settled) begin
                        if (hold == LOCK_LAST) begin
                            state <= IDLE;
                            hold  <= '0;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                    end else begin
                        hold <= '0;
                    end
                end
                // The first pressed cycle already counts towards the hold time.
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS;
                        hold  <= HW'(1);
                    end else begin
                        hold <= '0;
                    end
                end
                PRESS: begin
                    if (hold == HOLD_LAST) begin
                        state    <= FIRE;
                        reboot_n <= 1'b0;
                        busy     <= 1'b1;
                        pulse    <= '0;
                    end else if (!pressed) begin
                        state   <= IDLE;
                        img_sel <= (img_sel == SEL_LAST) ? 2'd0 : img_sel + 2'd1;
                    end else if (hold != HOLD_MAX) begin
                        hold <= hold + HW'(1);
                    end
                end
                FIRE: begin
                    if (pulse == PULSE_LAST) begin
                        reboot_n <= 1'b1;
                        state    <= WAIT_REL;
                    end else begin
                        pulse <= pulse + PW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!pressed) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= LOCKOUT;
            endcase
        end
    end

    assign REBOOT_N    = reboot_n;
    assign IMAGE_ADDR  = image_addr;
    assign IMG_SEL     = img_sel;
    assign KEY_PRESSED = pressed;
    assign BUSY        = busy;

endmodule

// File: tb/tb_mboot_req_ctrl.sv
// Randomized scoreboard bench for mboot_req_ctrl with a press-duration level model.
module tb_mboot_req_ctrl;

    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int PULSE  = 3;
    localparam int NIMG   = 3;
    localparam int BASE_I = 0;
    localparam int STR_I  = 10;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic       reboot_n;
    logic [7:0] image_addr;
    logic [1:0] img_sel;
    logic       key_pressed;
    logic       busy;

    int  cyc = 0;
    int  nchk = 0;
    int  nerr = 0;
    int  m_sel = 0;
    logic rst_q = 1'b1;

    int  kp_q[$];
    int  busy_q[$];
    ev_t sel_q[$];
    ev_t fire_q[$];

    mboot_req_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG),
        .PULSE_CYC   (PULSE),
        .NUM_IMG     (NIMG),
        .IMG_BASE    (8'h00),
        .IMG_STRIDE  (8'h0a)
    ) dut (
        .CLK_IN     (clk),
        .RST        (rst),
        .KEY_N      (key_n),
        .REBOOT_N   (reboot_n),
        .IMAGE_ADDR (image_addr),
        .IMG_SEL    (img_sel),
        .KEY_PRESSED(key_pressed),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic int model_addr(input int s);
        return (BASE_I + s * STR_I) % 256;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a clean press of len raw cycles is long when it outlasts LONG_CYC.
    task automatic press(input int len, input int gap);
        int  c;
        int  r;
        ev_t e;
        c = cyc;
        r = c + len;
        kp_q.push_back(c + 2 + DEB);
        if (len >= LONG) begin
            e.cyc = c + 2 + DEB + LONG;
            e.val = model_addr(m_sel);
            fire_q.push_back(e);
            busy_q.push_back(r + 3 + DEB);
        end else begin
            m_sel = (m_sel + 1) % NIMG;
            e.cyc = r + 3 + DEB;
            e.val = m_sel;
            sel_q.push_back(e);
        end
        key_n = 1'b0;
        tick(len);
        key_n = 1'b1;
        tick(gap);
    endtask

    task automatic glitch(input int lo, input int hi);
        key_n = 1'b0;
        tick(lo);
        key_n = 1'b1;
        tick(hi);
    endtask

    task automatic do_reset(input logic k);
        key_n = k;
        rst   = 1'b1;
        tick(3);
        rst   = 1'b0;
        m_sel = 0;
        if (!k) kp_q.push_back(cyc + 2 + DEB);
    endtask

    // Monitor: every output event pops its expectation from a queue.
    logic prev_kp = 1'b0;
    logic prev_rb = 1'b1;
    logic prev_busy = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    bit   addr_pend = 1'b0;
    int   addr_exp = 0;
    bit   in_pulse = 1'b0;
    int   pw = 0;
    int   fire_addr = 0;
    int   last_kp_rise = 0;
    ev_t  me;
    int   mi;

    always @(negedge clk) begin
        if (rst_q) begin
            in_pulse  = 1'b0;
            addr_pend = 1'b0;
        end else begin
            if (addr_pend) begin
                chk(int'(image_addr) == addr_exp, "image_addr_after_sel", int'(image_addr), addr_exp);
                addr_pend = 1'b0;
            end
            if (key_pressed && !prev_kp) begin
                last_kp_rise = cyc;
                chk(kp_q.size() > 0, "kp_rise_unexpected", cyc, -1);
                if (kp_q.size() > 0) begin
                    mi = kp_q.pop_front();
                    chk(cyc == mi, "kp_rise_cycle", cyc, mi);
                end
            end
            if (img_sel != prev_sel) begin
                chk(sel_q.size() > 0, "img_sel_unexpected", int'(img_sel), int'(prev_sel));
                if (sel_q.size() > 0) begin
                    me = sel_q.pop_front();
                    chk(int'(img_sel) == me.val, "img_sel_value", int'(img_sel), me.val);
                    chk(cyc == me.cyc, "img_sel_cycle", cyc, me.cyc);
                    addr_pend = 1'b1;
                    addr_exp  = model_addr(me.val);
                end
            end
            if (!reboot_n && prev_rb) begin
                chk(fire_q.size() > 0, "reboot_unexpected", cyc, -1);
                chk(cyc - last_kp_rise == LONG, "reboot_delay", cyc - last_kp_rise, LONG);
                if (fire_q.size() > 0) begin
                    me = fire_q.pop_front();
                    chk(cyc == me.cyc, "reboot_fall_cycle", cyc, me.cyc);
                    fire_addr = me.val;
                    in_pulse  = 1'b1;
                    pw        = 0;
                end
            end
            if (!reboot_n && in_pulse) begin
                pw++;
                chk(int'(image_addr) == fire_addr, "addr_during_pulse", int'(image_addr), fire_addr);
                chk(busy == 1'b1, "busy_during_pulse", int'(busy), 1);
            end
            if (reboot_n && !prev_rb && in_pulse) begin
                chk(pw == PULSE, "pulse_width", pw, PULSE);
                in_pulse = 1'b0;
            end
            if (!busy && prev_busy) begin
                chk(busy_q.size() > 0, "busy_fall_unexpected", cyc, -1);
                if (busy_q.size() > 0) begin
                    mi = busy_q.pop_front();
                    chk(cyc == mi, "busy_fall_cycle", cyc, mi);
                end
            end
        end
        prev_kp   = key_pressed;
        prev_rb   = reboot_n;
        prev_busy = busy;
        prev_sel  = img_sel;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int kind;
        int n;
        int f;

        // Reset state with key released.
        do_reset(1'b1);
        tick(2);
        chk(reboot_n == 1'b1, "reset_reboot_n", int'(reboot_n), 1);
        chk(image_addr == 8'h00, "reset_image_addr", int'(image_addr), 0);
        chk(img_sel == 2'd0, "reset_img_sel", int'(img_sel), 0);
        chk(key_pressed == 1'b0, "reset_key_pressed", int'(key_pressed), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        tick(4);

        // Three short presses: 1, 2, 0.
        for (int i = 0; i < 3; i++) press(10, 10);

        // Glitch bursts are filtered out.
        for (int i = 0; i < 5; i++) glitch(3, 1);
        tick(6);
        chk(key_pressed == 1'b0, "glitch_key_pressed", int'(key_pressed), 0);
        chk(int'(img_sel) == m_sel, "glitch_img_sel", int'(img_sel), m_sel);

        // Long press from image 2.
        press(5, 10);
        press(5, 10);
        press(40, 12);
        chk(int'(img_sel) == 2, "long_keeps_sel", int'(img_sel), 2);
        chk(image_addr == 8'h14, "long_keeps_addr", int'(image_addr), 20);

        // Key held through reset never fires; next long press does.
        do_reset(1'b0);
        tick(50);
        key_n = 1'b1;
        tick(15);
        chk(int'(img_sel) == 0, "held_reset_sel", int'(img_sel), 0);
        chk(reboot_n == 1'b1, "held_reset_reboot_n", int'(reboot_n), 1);
        press(30, 12);

        // Random mix of presses and glitches.
        for (int i = 0; i < 16; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                n = int'($urandom_range(1, 4));
                for (int j = 0; j < n; j++)
                    glitch(int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
                tick(6);
            end else if (kind == 3) begin
                press(int'($urandom_range(24, 40)), int'($urandom_range(8, 15)));
            end else begin
                press(int'($urandom_range(5, 14)), int'($urandom_range(8, 15)));
            end
        end

        // Reset during the reboot pulse.
        if (m_sel == 0) press(6, 10);
        begin
            ev_t e;
            kp_q.push_back(cyc + 2 + DEB);
            e.cyc = cyc + 2 + DEB + LONG;
            e.val = model_addr(m_sel);
            fire_q.push_back(e);
        end
        key_n = 1'b0;
        f = 0;
        for (int i = 0; i < 80 && f == 0; i++) begin
            tick(1);
            if (reboot_n == 1'b0) f = 1;
        end
        chk(f == 1, "reboot_wait_timeout", f, 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk(reboot_n == 1'b1, "midfire_reset_reboot_n", int'(reboot_n), 1);
        chk(img_sel == 2'd0, "midfire_reset_img_sel", int'(img_sel), 0);
        chk(busy == 1'b0, "midfire_reset_busy", int'(busy), 0);
        rst   = 1'b0;
        m_sel = 0;
        kp_q.push_back(cyc + 2 + DEB);
        tick(30);
        chk(reboot_n == 1'b1, "lockout_no_refire", int'(reboot_n), 1);
        key_n = 1'b1;
        tick(15);
        press(8, 12);
        tick(10);

        chk(kp_q.size() == 0, "kp_pending", kp_q.size(), 0);
        chk(sel_q.size() == 0, "sel_pending", sel_q.size(), 0);
        chk(fire_q.size() == 0, "fire_pending", fire_q.size(), 0);
        chk(busy_q.size() == 0, "busy_pending", busy_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
